pool_stream_unit: RTL and testbench

- Streaming max/average pooling engine placed between the systolic array output and the activation write-back path.
- Consumes a row-major feature-map stream, one activation per cycle, for one channel per start.
- Runtime-configurable map size and mode. Non-overlapping KxK windows with stride K.
- Emits one pooled value per completed window, with valid/ready flow control on both sides.

---
 rtl/pool_pkg.sv | 41 ++++
 rtl/pool_line_buf.sv | 30 +++
 rtl/pool_stream_unit.sv | 207 ++++++++++++++++++++
 tb/tb_pool_stream_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling engine.
// Holds the mode and FSM enums, the accumulator width helper and the
// max/add combine operator used by both the horizontal and vertical
// reduction stages.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pool_state_e;

    // Widest accumulator the combine helper handles; callers sign-extend into it.
    localparam int ACC_MAX_W = 32;

    // A KxK window sum of DATA_WIDTH values needs 2*log2(K) extra bits.
    function automatic int acc_width(input int dataWidth, input int poolK);
        return dataWidth + 2 * $clog2(poolK);
    endfunction

    // Max in max mode, sum in average mode; operands are already sign-extended.
    function automatic logic signed [ACC_MAX_W-1:0] combine(
        input pool_mode_e                   mode,
        input logic signed [ACC_MAX_W-1:0]  a,
        input logic signed [ACC_MAX_W-1:0]  b
    );
        logic signed [ACC_MAX_W-1:0] result;
        if (mode == POOL_AVG) begin
            result = a + b;
        end else begin
            result = (a > b) ? a : b;
        end
        return result;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Partial-window line buffer: one accumulator entry per window column.
// Synchronous write, combinational read, no reset (contents are only
// read after being written earlier in the same window row band).
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 10,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store a partial vertical result for one window column.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_stream_unit.sv
// Streaming KxK max/average pooling engine (stride K, floor mode).
// Pixels arrive row-major; each window is reduced horizontally in r_h and
// vertically through the line buffer, and the finished window lands in a
// single output register with valid/ready handshake.
// Optional build macro POOL_RELU_EN clamps negative results to zero.
module pool_stream_unit
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int POOL_K     = 2,
    parameter int MAX_COLS   = 64,
    parameter int DIM_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cfg_mode,
    input  logic [DIM_W-1:0]      cfg_rows,
    input  logic [DIM_W-1:0]      cfg_cols,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int ACC_W     = acc_width(DATA_WIDTH, POOL_K);
    localparam int KSH       = $clog2(POOL_K);
    localparam int AVG_SH    = 2 * KSH;
    localparam int BUF_DEPTH = MAX_COLS / POOL_K;
    localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int PAD       = ACC_MAX_W - ACC_W;
    localparam logic [DIM_W-1:0] K_MASK = DIM_W'(POOL_K - 1);

    pool_state_e              r_state;
    pool_state_e              w_nextState;
    pool_mode_e               r_mode;
    logic [DIM_W-1:0]         r_rows;
    logic [DIM_W-1:0]         r_cols;
    logic [DIM_W-1:0]         r_row;
    logic [DIM_W-1:0]         r_col;
    logic signed [ACC_W-1:0]  r_h;
    logic                     r_outValid;
    logic [DATA_WIDTH-1:0]    r_outData;
    logic                     r_zeroDone;

    logic                     w_fire;
    logic                     w_lastCol;
    logic                     w_lastPix;
    logic                     w_inWin;
    logic                     w_endCol;
    logic                     w_endRow;
    logic                     w_firstRow;
    logic                     w_startCol;
    logic                     w_flushDone;
    logic                     w_we;
    logic                     w_loadOut;
    logic [BUF_AW-1:0]        w_bufAddr;
    logic signed [ACC_W-1:0]  w_pixExt;
    logic signed [ACC_W-1:0]  w_hv;
    logic signed [ACC_W-1:0]  w_bufRd;
    logic signed [ACC_W-1:0]  w_merged;
    logic signed [ACC_W-1:0]  w_wdata;
    logic [DATA_WIDTH-1:0]    w_conv;

    // Narrow wrapper around the package combine operator.
    function automatic logic signed [ACC_W-1:0] combAcc(
        input pool_mode_e              m,
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        return ACC_W'(combine(m, {{PAD{a[ACC_W-1]}}, a}, {{PAD{b[ACC_W-1]}}, b}));
    endfunction

    assign w_fire      = in_valid & in_ready;
    assign w_lastCol   = (r_col == r_cols - 1'b1);
    assign w_lastPix   = w_lastCol & (r_row == r_rows - 1'b1);
    assign w_inWin     = (r_col < (r_cols & ~K_MASK)) && (r_row < (r_rows & ~K_MASK));
    assign w_startCol  = ((r_col & K_MASK) == '0);
    assign w_endCol    = ((r_col & K_MASK) == K_MASK);
    assign w_firstRow  = ((r_row & K_MASK) == '0);
    assign w_endRow    = ((r_row & K_MASK) == K_MASK);
    assign w_bufAddr   = BUF_AW'(r_col >> KSH);
    assign w_flushDone = (r_state == FLUSH) && !r_outValid;

    assign in_ready  = (r_state == RUN) && (!r_outValid || out_ready);
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign busy      = (r_state != IDLE);
    assign done      = w_flushDone | r_zeroDone;

    pool_line_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ACC_W),
        .AW    (BUF_AW)
    ) u_lineBuf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_bufAddr),
        .i_wdata (w_wdata),
        .i_raddr (w_bufAddr),
        .o_rdata (w_bufRd)
    );

    // Window datapath: horizontal reduce, merge with the line buffer, convert.
    always_comb begin
        w_pixExt  = {{(ACC_W - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
        w_hv      = w_startCol ? w_pixExt : combAcc(r_mode, r_h, w_pixExt);
        w_merged  = combAcc(r_mode, w_bufRd, w_hv);
        w_wdata   = w_firstRow ? w_hv : w_merged;
        w_we      = w_fire && w_inWin && w_endCol && !w_endRow;
        w_loadOut = w_fire && w_inWin && w_endCol && w_endRow;
        if (r_mode == POOL_AVG) begin
            w_conv = DATA_WIDTH'(w_merged >>> AVG_SH);
        end else begin
            w_conv = DATA_WIDTH'(w_merged);
        end
`ifdef POOL_RELU_EN
        if (w_merged[ACC_W-1]) begin
            w_conv = '0;
        end
`endif
    end

    // Next-state logic; zero-sized maps never leave IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start && (cfg_rows != '0) && (cfg_cols != '0)) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_fire && w_lastPix) begin
                    w_nextState = FLUSH;
                end
            end
            FLUSH: begin
                if (!r_outValid) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Configuration latch, pixel counters and horizontal accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= POOL_MAX;
            r_rows     <= '0;
            r_cols     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_h        <= '0;
            r_zeroDone <= 1'b0;
        end else begin
            r_zeroDone <= (r_state == IDLE) && start && ((cfg_rows == '0) || (cfg_cols == '0));
            if (r_state == IDLE) begin
                if (start) begin
                    r_mode <= pool_mode_e'(cfg_mode);
                    r_rows <= cfg_rows;
                    r_cols <= cfg_cols;
                    r_row  <= '0;
                    r_col  <= '0;
                end
            end else if (w_fire) begin
                if (w_lastCol) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_inWin) begin
                    r_h <= w_hv;
                end
            end
        end
    end

    // Output register: load on window completion, drop once taken downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (w_loadOut) begin
            r_outValid <= 1'b1;
            r_outData  <= w_conv;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Scoreboard bench for pool_stream_unit (K=2, 8-bit data).
// Expected pooled values are pushed when a map is issued; a monitor pops
// and compares on every accepted output.
module tb_pool_stream_unit;

    localparam int DW    = 8;
    localparam int DIM_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              cfg_mode;
    logic [DIM_W-1:0]  cfg_rows;
    logic [DIM_W-1:0]  cfg_cols;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    int checkCount = 0;
    int passCount  = 0;
    int doneCount  = 0;
    int stallCount = 0;
    logic signed [DW-1:0] expQ[$];

    pool_stream_unit #(
        .DATA_WIDTH (DW),
        .POOL_K     (2),
        .MAX_COLS   (64),
        .DIM_W      (DIM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_mode  (cfg_mode),
        .cfg_rows  (cfg_rows),
        .cfg_cols  (cfg_cols),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the monitor and the directed tests.
    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: count done pulses and score every accepted output.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) doneCount++;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_output: got %0d, expected none", $signed(out_data));
                end else begin
                    checkOutput("pool_result", $signed(out_data), expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic startMap(input logic mode, input logic [DIM_W-1:0] rows,
                            input logic [DIM_W-1:0] cols);
        @(posedge clk); #1;
        cfg_mode = mode;
        cfg_rows = rows;
        cfg_cols = cols;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Present one pixel and hold it until accepted (bounded); optional stray start.
    task automatic applyStimulus(input logic signed [DW-1:0] pix, input bit glitch);
        int waited;
        in_valid = 1'b1;
        in_data  = pix;
        if (glitch) begin
            start    = 1'b1;
            cfg_rows = 8'd0;
            cfg_cols = 8'd2;
        end
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            stallCount++;
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checkCount++;
            $display("[TB] FAIL pixel_accept_timeout: in_ready=%0b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic sendSeq(input int n, input int glitchIdx);
        for (int i = 0; i < n; i++) begin
            applyStimulus(DW'(i + 1), (i == glitchIdx));
        end
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (busy) begin
            checkCount++;
            $display("[TB] FAIL idle_timeout: busy=%0b, expected 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic pushMax4x4();
        expQ.push_back(8'sd6);
        expQ.push_back(8'sd8);
        expQ.push_back(8'sd14);
        expQ.push_back(8'sd16);
    endtask

    initial begin
        int d0;
        int waited;
        rst       = 1'b0;
        start     = 1'b0;
        cfg_mode  = 1'b0;
        cfg_rows  = '0;
        cfg_cols  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {in_ready, out_valid, busy, done, out_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] max 4x4, free-running output");
        d0 = doneCount;
        stallCount = 0;
        pushMax4x4();
        startMap(1'b0, 8'd4, 8'd4);
        sendSeq(16, -1);
        waitIdle();
        checkOutput("max4x4_done", doneCount - d0, 1);
        checkOutput("max4x4_stalls", stallCount, 0);
        checkOutput("max4x4_drained", expQ.size(), 0);

        $display("[TB] avg 2x2 negative");
        d0 = doneCount;
`ifdef POOL_RELU_EN
        expQ.push_back(8'sd0);
`else
        expQ.push_back(-8'sd3);
`endif
        startMap(1'b1, 8'd2, 8'd2);
        applyStimulus(-8'sd1, 1'b0);
        applyStimulus(-8'sd2, 1'b0);
        applyStimulus(-8'sd3, 1'b0);
        applyStimulus(-8'sd4, 1'b0);
        waitIdle();
        checkOutput("avg2x2_done", doneCount - d0, 1);
        checkOutput("avg2x2_drained", expQ.size(), 0);

        $display("[TB] max 4x4 with backpressure");
        d0 = doneCount;
        out_ready = 1'b0;
        pushMax4x4();
        startMap(1'b0, 8'd4, 8'd4);
        fork
            sendSeq(16, -1);
            begin
                waited = 0;
                @(negedge clk);
                while (!out_valid && waited < 200) begin
                    waited++;
                    @(negedge clk);
                end
                checkOutput("bp_first_valid", out_valid, 1);
                for (int k = 0; k < 5; k++) begin
                    checkOutput("bp_in_ready_low", in_ready, 0);
                    checkOutput("bp_data_hold", $signed(out_data), 6);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("bp_done", doneCount - d0, 1);
        checkOutput("bp_drained", expQ.size(), 0);

        $display("[TB] max 5x5 odd size");
        d0 = doneCount;
        expQ.push_back(8'sd7);
        expQ.push_back(8'sd9);
        expQ.push_back(8'sd17);
        expQ.push_back(8'sd19);
        startMap(1'b0, 8'd5, 8'd5);
        sendSeq(25, -1);
        waitIdle();
        checkOutput("odd5x5_done", doneCount - d0, 1);
        checkOutput("odd5x5_drained", expQ.size(), 0);

        $display("[TB] zero-size config");
        d0 = doneCount;
        startMap(1'b0, 8'd0, 8'd4);
        @(negedge clk);
        checkOutput("zero_done_pulse", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_no_valid", out_valid, 0);
        @(negedge clk);
        checkOutput("zero_done_once", done, 0);
        checkOutput("zero_still_idle", busy, 0);
        checkOutput("zero_done_count", doneCount - d0, 1);

        $display("[TB] start during run is ignored");
        d0 = doneCount;
        pushMax4x4();
        startMap(1'b0, 8'd4, 8'd4);
        sendSeq(16, 5);
        waitIdle();
        checkOutput("glitch_done", doneCount - d0, 1);
        checkOutput("glitch_drained", expQ.size(), 0);

        $display("[TB] reset mid-map");
        startMap(1'b0, 8'd4, 8'd4);
        sendSeq(6, -1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_outputs", {in_ready, out_valid, busy, done, out_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = doneCount;
        pushMax4x4();
        startMap(1'b0, 8'd4, 8'd4);
        sendSeq(16, -1);
        waitIdle();
        checkOutput("postreset_done", doneCount - d0, 1);

        checkOutput("final_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
